// File: rtl/calc_score_array_if.sv
// Bus bundle for calc_score_array: table writes, sweep control, score stream and best-task report.
interface calc_score_array_if #(
  parameter int IDX_W          = 3,
  parameter int SCORE_BITWIDTH = 32,
  parameter int TIME_WIDTH     = 16
);
  logic                      cfg_we;
  logic [IDX_W-1:0]          cfg_idx;
  logic                      cfg_entry_vld;
  logic [SCORE_BITWIDTH-1:0] cfg_avg_lat;
  logic [SCORE_BITWIDTH-1:0] cfg_linear_rate;
  logic [15:0]               cfg_norm_iso;
  logic [TIME_WIDTH-1:0]     cfg_exe_clk;
  logic [TIME_WIDTH-1:0]     cfg_ddl;
  logic [TIME_WIDTH-1:0]     sys_clk;
  logic                      start;
  logic                      busy;
  logic                      score_vld;
  logic                      score_rdy;
  logic [SCORE_BITWIDTH-1:0] score_dat;
  logic [IDX_W-1:0]          score_id;
  logic                      done;
  logic                      best_vld;
  logic [IDX_W-1:0]          best_id;
  logic [SCORE_BITWIDTH-1:0] best_score;

  modport master (
    output cfg_we, cfg_idx, cfg_entry_vld, cfg_avg_lat, cfg_linear_rate, cfg_norm_iso,
           cfg_exe_clk, cfg_ddl, sys_clk, start, score_rdy,
    input  busy, score_vld, score_dat, score_id, done, best_vld, best_id, best_score
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_entry_vld, cfg_avg_lat, cfg_linear_rate, cfg_norm_iso,
           cfg_exe_clk, cfg_ddl, sys_clk, start, score_rdy,
    output busy, score_vld, score_dat, score_id, done, best_vld, best_id, best_score
  );
endinterface

// File: rtl/calc_score_array.sv
// Task-table score engine: each start sweeps every entry through a 4-stage fixed-point
// pipeline, streams per-task scores and reports the lowest-scoring task at sweep end.
module calc_score_array #(
  parameter  int NUM_TASKS      = 8,
  parameter  int SCORE_BITWIDTH = 32,
  parameter  int TIME_WIDTH     = 16,
  parameter  int FRAC_BITS      = 8,
  parameter  int BETA_Q         = 3,
  localparam int IDX_W          = $clog2(NUM_TASKS)
) (
  input logic               clk,
  input logic               reset,
  calc_score_array_if.slave bus
);
  localparam int SB     = SCORE_BITWIDTH;
  localparam int TW     = TIME_WIDTH;
  localparam int CW     = 2 * SB;
  localparam int STAGES = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic          vld;
    logic [SB-1:0] lat;
    logic [SB-1:0] rate;
    logic [15:0]   iso;
    logic [TW-1:0] exe;
    logic [TW-1:0] ddl;
  } entry_t;

  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [SB-1:0]    lat;
    logic [SB-1:0]    rate;
    logic [15:0]      iso;
    logic [TW-1:0]    slack;
    logic [TW-1:0]    age;
  } s1_t;

  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [SB-1:0]    est;
    logic [SB-1:0]    cost;
  } s2_t;

  typedef struct packed {
    logic [IDX_W-1:0] id;
    logic [SB-1:0]    est;
    logic [SB-1:0]    bcost;
  } s3_t;

  function automatic logic [SB-1:0] sat(input logic [CW-1:0] x);
    return (|x[CW-1:SB]) ? '1 : x[SB-1:0];
  endfunction

  state_t           state_q;
  logic [IDX_W-1:0] issue_idx_q;
  logic [TW-1:0]    snap_q;
  logic             busy_q, done_q;

  entry_t tbl_q [NUM_TASKS];
  entry_t tbl_d [NUM_TASKS];

  // occ_pipe tracks every injected slot (bubbles too) so sweep length is fixed;
  // vld_pipe tracks only slots carrying a real score.
  logic [STAGES:1]  vld_pipe_q, vld_pipe_d;
  logic [STAGES:1]  occ_pipe_q, occ_pipe_d;
  s1_t              s1_q, s1_d;
  s2_t              s2_q, s2_d;
  s3_t              s3_q, s3_d;
  logic [SB-1:0]    score_q, score_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic             best_vld_q, best_vld_d;
  logic [IDX_W-1:0] best_id_q, best_id_d;
  logic [SB-1:0]    best_score_q, best_score_d;

  logic          en, inject, accept, hs;
  entry_t        ent;
  logic [TW:0]   slack_w;
  logic [CW-1:0] est_w, cost_w, bc_w;
  logic [SB:0]   sum_w;

  always_comb begin
    en      = !(vld_pipe_q[STAGES] && !bus.score_rdy);
    inject  = (state_q == ISSUE) && en;
    accept  = (state_q == IDLE) && bus.start;
    hs      = vld_pipe_q[STAGES] && bus.score_rdy;
    ent     = tbl_q[issue_idx_q];
    slack_w = {1'b0, ent.ddl} - {1'b0, snap_q};
    est_w   = CW'(s1_q.rate) * CW'(s1_q.lat);
    cost_w  = (CW'(s1_q.slack) << FRAC_BITS) + CW'(s1_q.iso) * CW'(s1_q.age);
    bc_w    = (CW'(BETA_Q) * CW'(s2_q.cost)) >> FRAC_BITS;
    sum_w   = {1'b0, s3_q.est} + {1'b0, s3_q.bcost};

    tbl_d = tbl_q;
    if (bus.cfg_we)
      tbl_d[bus.cfg_idx] = '{vld: bus.cfg_entry_vld, lat: bus.cfg_avg_lat,
                             rate: bus.cfg_linear_rate, iso: bus.cfg_norm_iso,
                             exe: bus.cfg_exe_clk, ddl: bus.cfg_ddl};

    vld_pipe_d = vld_pipe_q;
    occ_pipe_d = occ_pipe_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    s3_d       = s3_q;
    score_d    = score_q;
    id_d       = id_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[STAGES-1:1], inject && ent.vld};
      occ_pipe_d = {occ_pipe_q[STAGES-1:1], inject};
      s1_d = '{id: issue_idx_q, lat: ent.lat, rate: ent.rate, iso: ent.iso,
               slack: slack_w[TW] ? '0 : slack_w[TW-1:0], age: snap_q - ent.exe};
      s2_d = '{id: s1_q.id, est: sat(est_w), cost: sat(cost_w)};
      s3_d = '{id: s2_q.id, est: s2_q.est, bcost: sat(bc_w)};
      // Output regs load only on a real score so a stall or trailing bubble keeps them stable.
      if (vld_pipe_q[STAGES-1]) begin
        score_d = sum_w[SB] ? '1 : sum_w[SB-1:0];
        id_d    = s3_q.id;
      end
    end

    best_vld_d   = best_vld_q;
    best_id_d    = best_id_q;
    best_score_d = best_score_q;
    if (accept) begin
      best_vld_d   = 1'b0;
      best_id_d    = '0;
      best_score_d = '0;
    end else if (hs && (!best_vld_q || score_q < best_score_q)) begin
      best_vld_d   = 1'b1;
      best_id_d    = id_q;
      best_score_d = score_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      snap_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            snap_q      <= bus.sys_clk;
            issue_idx_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: if (en) begin
          issue_idx_q <= issue_idx_q + 1'b1;
          if (issue_idx_q == IDX_W'(NUM_TASKS - 1)) state_q <= DRAIN;
        end
        DRAIN: if (en && occ_pipe_q[STAGES-1:1] == '0) begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TASKS; i++) tbl_q[i] <= '0;
      vld_pipe_q   <= '0;
      occ_pipe_q   <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      score_q      <= '0;
      id_q         <= '0;
      best_vld_q   <= 1'b0;
      best_id_q    <= '0;
      best_score_q <= '0;
    end else begin
      tbl_q        <= tbl_d;
      vld_pipe_q   <= vld_pipe_d;
      occ_pipe_q   <= occ_pipe_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      score_q      <= score_d;
      id_q         <= id_d;
      best_vld_q   <= best_vld_d;
      best_id_q    <= best_id_d;
      best_score_q <= best_score_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.score_vld  = vld_pipe_q[STAGES];
  assign bus.score_dat  = score_q;
  assign bus.score_id   = id_q;
  assign bus.best_vld   = best_vld_q;
  assign bus.best_id    = best_id_q;
  assign bus.best_score = best_score_q;
endmodule

// File: tb/tb_calc_score_array.sv
// Scoreboard bench for calc_score_array: a reference score model fills a queue at start,
// results are popped and compared as they handshake out.
module tb_calc_score_array;
  localparam int N = 8;
  localparam logic [31:0] MAX = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  calc_score_array_if bus ();
  calc_score_array dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { int id; logic [31:0] sc; } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic        m_vld [N];
  logic [31:0] m_lat [N];
  logic [31:0] m_rate[N];
  logic [15:0] m_iso [N];
  logic [15:0] m_exe [N];
  logic [15:0] m_ddl [N];

  function automatic logic [31:0] model_score(input int i, input logic [15:0] sys);
    logic [63:0] est, slack, cost, bc, s;
    logic [15:0] age;
    est   = 64'(m_rate[i]) * 64'(m_lat[i]);
    slack = (m_ddl[i] >= sys) ? 64'(m_ddl[i] - sys) : 64'd0;
    age   = sys - m_exe[i];
    cost  = slack * 256 + 64'(m_iso[i]) * 64'(age);
    if (cost > 64'(MAX)) cost = 64'(MAX);
    bc = (cost * 3) / 256;
    if (est > 64'(MAX)) return MAX;
    s = est + bc;
    return (s > 64'(MAX)) ? MAX : s[31:0];
  endfunction

  task automatic cfg_write(input int idx, input logic v, input logic [31:0] lat, input logic [31:0] rate,
                           input logic [15:0] iso, input logic [15:0] exe, input logic [15:0] ddl);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_entry_vld = v;
    bus.cfg_avg_lat = lat; bus.cfg_linear_rate = rate; bus.cfg_norm_iso = iso;
    bus.cfg_exe_clk = exe; bus.cfg_ddl = ddl;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    m_vld[idx] = v; m_lat[idx] = lat; m_rate[idx] = rate;
    m_iso[idx] = iso; m_exe[idx] = exe; m_ddl[idx] = ddl;
  endtask

  // One sweep: pushes expectations, pulses start, drains results, checks done timing and best.
  task automatic do_sweep(input string tag, input int stall_len, input bit restart);
    logic        eb_vld = 1'b0;
    int          eb_id  = 0;
    logic [31:0] eb_sc  = '0;
    logic [31:0] hold_dat = '0;
    logic [2:0]  hold_id  = '0;
    int          stall_cnt = 0;
    int          lat = -1;
    exp_t        e;
    for (int i = 0; i < N; i++) if (m_vld[i]) begin
      e.id = i; e.sc = model_score(i, bus.sys_clk);
      exp_q.push_back(e);
      if (!eb_vld || e.sc < eb_sc) begin eb_vld = 1'b1; eb_id = i; eb_sc = e.sc; end
    end
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 1) begin
        bus.start = restart ? 1'b0 : 1'b0;
        n_chk++;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL %s busy_rise: got %0b want 1", tag, bus.busy); end
      end
      if (restart && cyc == 3) bus.start = 1'b1;
      if (restart && cyc == 4) bus.start = 1'b0;
      if (bus.done === 1'b1) begin lat = cyc; break; end
      if (bus.score_vld && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          hold_dat = bus.score_dat; hold_id = bus.score_id;
        end else begin
          n_chk++;
          if (bus.score_dat !== hold_dat || bus.score_id !== hold_id) begin
            n_err++;
            $display("FAIL %s stall_stable: got id=%0d dat=%0d want id=%0d dat=%0d", tag,
                     bus.score_id, bus.score_dat, hold_id, hold_dat);
          end
        end
        bus.score_rdy = 1'b0;
        stall_cnt++;
      end else begin
        bus.score_rdy = 1'b1;
        if (bus.score_vld) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL %s extra_score: got id=%0d dat=%0d want none", tag, bus.score_id, bus.score_dat);
          end else begin
            e = exp_q.pop_front();
            if (bus.score_id !== 3'(e.id) || bus.score_dat !== e.sc) begin
              n_err++;
              $display("FAIL %s score: got id=%0d dat=%0d want id=%0d dat=%0d", tag,
                       bus.score_id, bus.score_dat, e.id, e.sc);
            end
          end
        end
      end
    end
    bus.score_rdy = 1'b1;
    n_chk++;
    if (lat != N + 5 + stall_len) begin
      n_err++; $display("FAIL %s done_latency: got %0d want %0d", tag, lat, N + 5 + stall_len);
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL %s missing_scores: got %0d left want 0", tag, exp_q.size());
      exp_q.delete();
    end
    n_chk++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL %s busy_at_done: got %0b want 0", tag, bus.busy); end
    n_chk++;
    if (bus.best_vld !== eb_vld || (eb_vld && (bus.best_id !== 3'(eb_id) || bus.best_score !== eb_sc))) begin
      n_err++;
      $display("FAIL %s best: got vld=%0b id=%0d sc=%0d want vld=%0b id=%0d sc=%0d", tag,
               bus.best_vld, bus.best_id, bus.best_score, eb_vld, eb_id, eb_sc);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_chk++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.score_vld !== 1'b0) begin
        n_err++;
        $display("FAIL %s after_done: got done=%0b busy=%0b vld=%0b want 0 0 0", tag, bus.done, bus.busy, bus.score_vld);
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_chk++;
    if ({bus.busy, bus.score_vld, bus.done, bus.best_vld} !== 4'b0 || bus.score_dat !== '0 ||
        bus.score_id !== '0 || bus.best_id !== '0 || bus.best_score !== '0) begin
      n_err++;
      $display("FAIL %s outputs_zero: got busy=%0b vld=%0b done=%0b bvld=%0b dat=%0d id=%0d bid=%0d bsc=%0d want all 0",
               tag, bus.busy, bus.score_vld, bus.done, bus.best_vld, bus.score_dat, bus.score_id,
               bus.best_id, bus.best_score);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("reset");
  endtask

  task automatic test_single();
    cfg_write(0, 1'b1, 100, 256, 128, 10, 1000);
    bus.sys_clk = 16'd200;
    do_sweep("single", 0, 1'b0);
    n_chk++;
    if (bus.best_score !== 32'd28285) begin
      n_err++; $display("FAIL single_literal: got %0d want 28285", bus.best_score);
    end
  endtask

  task automatic test_missed_ddl();
    cfg_write(0, 1'b1, 100, 256, 128, 10, 150);
    do_sweep("missed_ddl", 0, 1'b0);
    n_chk++;
    if (bus.best_score !== 32'd25885) begin
      n_err++; $display("FAIL missed_ddl_literal: got %0d want 25885", bus.best_score);
    end
  endtask

  task automatic test_back_to_back();
    cfg_write(0, 1'b1, 100, 256, 128, 10, 1000);
    cfg_write(3, 1'b1, 100, 256, 128, 10, 900);
    do_sweep("two_lower3", 0, 1'b1);
    cfg_write(3, 1'b1, 100, 256, 128, 10, 1000);
    do_sweep("two_tie", 0, 1'b0);
  endtask

  task automatic test_stall();
    cfg_write(3, 1'b1, 50, 512, 64, 100, 300);
    bus.sys_clk = 16'd250;
    do_sweep("stall", 5, 1'b0);
  endtask

  task automatic test_saturate();
    cfg_write(3, 1'b0, 0, 0, 0, 0, 0);
    cfg_write(0, 1'b1, 32'h0100_0000, 32'h0001_0000, 128, 10, 1000);
    do_sweep("saturate", 0, 1'b0);
    n_chk++;
    if (bus.best_score !== MAX) begin
      n_err++; $display("FAIL saturate_literal: got %h want ffffffff", bus.best_score);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    cfg_write(0, 1'b1, 100, 256, 128, 10, 1000);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < N; i++) m_vld[i] = 1'b0;
    check_zero_outputs("reset_mid");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done || bus.score_vld) seen++;
    end
    n_chk++;
    if (seen != 0) begin n_err++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen); end
    do_sweep("all_invalid", 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_entry_vld = 1'b0;
    bus.cfg_avg_lat = '0; bus.cfg_linear_rate = '0; bus.cfg_norm_iso = '0;
    bus.cfg_exe_clk = '0; bus.cfg_ddl = '0; bus.sys_clk = '0;
    bus.start = 1'b0; bus.score_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_vld[i] = 1'b0; m_lat[i] = '0; m_rate[i] = '0; m_iso[i] = '0; m_exe[i] = '0; m_ddl[i] = '0;
    end
    test_reset();
    test_single();
    test_missed_ddl();
    test_back_to_back();
    test_stall();
    test_saturate();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
